// File: rtl/hsem_lock_arbiter.sv
// rtl/hsem_lock_arbiter.sv - two-core HSEM lock/release sequencer with round-robin contention
`timescale 1ns/1ps
module hsem_lock_arbiter #(
   parameter int NUM_SEM      = 8,
   parameter int SEMNUM_WIDTH = 3,
   parameter int PROCID_WIDTH = 8
) (
   input  logic                    hclk,
   input  logic                    hresetn,
   input  logic                    c0_req,
   input  logic                    c0_op,
   input  logic [SEMNUM_WIDTH-1:0] c0_sem,
   input  logic [PROCID_WIDTH-1:0] c0_procid,
   output logic                    c0_ack,
   output logic                    c0_grant,
   output logic                    c0_err,
   input  logic                    c1_req,
   input  logic                    c1_op,
   input  logic [SEMNUM_WIDTH-1:0] c1_sem,
   input  logic [PROCID_WIDTH-1:0] c1_procid,
   output logic                    c1_ack,
   output logic                    c1_grant,
   output logic                    c1_err,
   output logic [NUM_SEM-1:0]      sem_locked,
   output logic [NUM_SEM-1:0]      sem_owner,
   output logic [NUM_SEM-1:0]      release_evt,
   output logic                    err_valid,
   output logic [2:0]              err_code,
   output logic [SEMNUM_WIDTH-1:0] err_semnum,
   output logic                    err_faultid
);

   localparam logic [2:0] CODE_FREE  = 3'b001;
   localparam logic [2:0] CODE_OWNER = 3'b010;
   localparam logic [2:0] CODE_INDEX = 3'b100;

   logic [NUM_SEM-1:0]      r_locked;
   logic [NUM_SEM-1:0]      r_owner;
   logic [NUM_SEM-1:0]      r_evt;
   logic [PROCID_WIDTH-1:0] r_procid [NUM_SEM];
   logic                    r_rr;
   logic [1:0]              r_ack;
   logic [1:0]              r_grant;
   logic [1:0]              r_err;
   logic                    r_err_valid;
   logic [2:0]              r_err_code;
   logic [SEMNUM_WIDTH-1:0] r_err_semnum;
   logic                    r_err_faultid;

   logic [1:0]              w_req;
   logic [1:0]              w_op;
   logic [SEMNUM_WIDTH-1:0] w_sem [2];
   logic [PROCID_WIDTH-1:0] w_pid [2];
   logic [1:0]              w_elig;
   logic [1:0]              w_svc;
   logic                    w_conflict;
   logic [1:0]              w_in_range;
   logic [1:0]              w_hit_locked;
   logic [1:0]              w_hit_owner;
   logic [PROCID_WIDTH-1:0] w_hit_pid [2];
   logic [1:0]              w_match;
   logic [1:0]              w_grant;
   logic [1:0]              w_err;
   logic [2:0]              w_code [2];
   logic [1:0]              w_do_lock;
   logic [1:0]              w_do_rel;

   assign w_req    = {c1_req, c0_req};
   assign w_op     = {c1_op, c0_op};
   assign w_sem[0] = c0_sem;
   assign w_sem[1] = c1_sem;
   assign w_pid[0] = c0_procid;
   assign w_pid[1] = c1_procid;

   // A port is blind during its own ack cycle so a held request is never serviced twice
   assign w_elig     = w_req & ~r_ack;
   assign w_conflict = (&w_elig) && (w_sem[0] == w_sem[1]);
   assign w_svc[0]   = w_elig[0] & (~w_conflict | ~r_rr);
   assign w_svc[1]   = w_elig[1] & (~w_conflict | r_rr);

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         w_hit_locked[k] = 1'b0;
         w_hit_owner[k]  = 1'b0;
         w_hit_pid[k]    = '0;
         for (int i = 0; i < NUM_SEM; i++) begin
            if (w_sem[k] == SEMNUM_WIDTH'(i)) begin
               w_hit_locked[k] = r_locked[i];
               w_hit_owner[k]  = r_owner[i];
               w_hit_pid[k]    = r_procid[i];
            end
         end
         w_in_range[k] = ({1'b0, w_sem[k]} < (SEMNUM_WIDTH+1)'(NUM_SEM));
         w_match[k]    = w_hit_locked[k] & (w_hit_owner[k] == 1'(k)) & (w_hit_pid[k] == w_pid[k]);
         if (!w_op[k]) begin
            w_grant[k]   = w_in_range[k] & (~w_hit_locked[k] | w_match[k]);
            w_err[k]     = ~w_in_range[k];
            w_code[k]    = w_in_range[k] ? 3'b000 : CODE_INDEX;
            w_do_lock[k] = w_svc[k] & w_in_range[k] & ~w_hit_locked[k];
            w_do_rel[k]  = 1'b0;
         end else begin
            w_grant[k]   = w_in_range[k] & w_match[k];
            w_err[k]     = ~(w_in_range[k] & w_match[k]);
            w_code[k]    = !w_in_range[k]   ? CODE_INDEX :
                           !w_hit_locked[k] ? CODE_FREE  :
                           w_match[k]       ? 3'b000     : CODE_OWNER;
            w_do_lock[k] = 1'b0;
            w_do_rel[k]  = w_svc[k] & w_in_range[k] & w_match[k];
         end
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_locked      <= '0;
         r_owner       <= '0;
         r_evt         <= '0;
         for (int i = 0; i < NUM_SEM; i++) r_procid[i] <= '0;
         r_rr          <= 1'b0;
         r_ack         <= '0;
         r_grant       <= '0;
         r_err         <= '0;
         r_err_valid   <= 1'b0;
         r_err_code    <= '0;
         r_err_semnum  <= '0;
         r_err_faultid <= 1'b0;
      end else begin
         r_ack   <= w_svc;
         r_grant <= w_svc & w_grant;
         r_err   <= w_svc & w_err;
         r_evt   <= '0;
         // Both cores never touch the same semaphore in one cycle, so these updates cannot collide
         for (int i = 0; i < NUM_SEM; i++) begin
            for (int k = 0; k < 2; k++) begin
               if (w_sem[k] == SEMNUM_WIDTH'(i)) begin
                  if (w_do_lock[k]) begin
                     r_locked[i] <= 1'b1;
                     r_owner[i]  <= 1'(k);
                     r_procid[i] <= w_pid[k];
                  end
                  if (w_do_rel[k]) begin
                     r_locked[i] <= 1'b0;
                     r_owner[i]  <= 1'b0;
                     r_procid[i] <= '0;
                     r_evt[i]    <= 1'b1;
                  end
               end
            end
         end
         if (w_conflict) r_rr <= ~r_rr;
         r_err_valid <= |(w_svc & w_err);
         if (w_svc[0] && w_err[0]) begin
            r_err_code    <= w_code[0];
            r_err_semnum  <= w_sem[0];
            r_err_faultid <= 1'b0;
         end else if (w_svc[1] && w_err[1]) begin
            r_err_code    <= w_code[1];
            r_err_semnum  <= w_sem[1];
            r_err_faultid <= 1'b1;
         end else begin
            r_err_code    <= '0;
            r_err_semnum  <= '0;
            r_err_faultid <= 1'b0;
         end
      end
   end

   assign c0_ack      = r_ack[0];
   assign c0_grant    = r_grant[0];
   assign c0_err      = r_err[0];
   assign c1_ack      = r_ack[1];
   assign c1_grant    = r_grant[1];
   assign c1_err      = r_err[1];
   assign sem_locked  = r_locked;
   assign sem_owner   = r_owner;
   assign release_evt = r_evt;
   assign err_valid   = r_err_valid;
   assign err_code    = r_err_code;
   assign err_semnum  = r_err_semnum;
   assign err_faultid = r_err_faultid;

endmodule
